spi3_master: RTL and testbench

//  SPI master (mode 0, MSB first) driving the CN2 SPI pins (SCLK, COPI, XSS_0..2, CIPO_0..2)
//  in CQ_MAX10_TOP. Sits between on-chip request logic (sensor/ADC pollers, JTAG debug

---
 rtl/spi3_master.sv | 200 ++++++++++++++++++++
 tb/tb_spi3_master.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi3_master.sv
`default_nettype none
// ============================================================================
// Module   : spi3_master
// Purpose  : Mode-0, MSB-first SPI master for three slaves. Each request runs
//            one full-duplex frame and returns the received word with a DONE
//            pulse.
// Revision : 1.0 - initial release
// ============================================================================
module spi3_master #(
    parameter int C_F_CK   = 135_000_000,
    parameter int C_F_SCLK = 1_000_000,
    parameter int C_DW     = 16
) (
    input  logic            CK_i,
    input  logic            ARST_i,
    input  logic            REQ_i,
    input  logic [1:0]      SEL_i,
    input  logic [C_DW-1:0] TX_DAT_i,
    output logic            BUSY_o,
    output logic            DONE_o,
    output logic [C_DW-1:0] RX_DAT_o,
    output logic            SCLK_o,
    output logic            COPI_o,
    output logic            XSS_0_o,
    output logic            XSS_1_o,
    output logic            XSS_2_o,
    input  logic            CIPO_0_i,
    input  logic            CIPO_1_i,
    input  logic            CIPO_2_i
);

    localparam int C_H_RAW = C_F_CK / (2 * C_F_SCLK);
    localparam int C_H     = (C_H_RAW < 1) ? 1 : C_H_RAW;
    localparam int C_CW    = (C_H > 1) ? $clog2(C_H) : 1;
    localparam int C_BW    = $clog2(C_DW + 1);

    localparam logic [C_CW-1:0] C_HLAST   = C_CW'(C_H - 1);
    localparam logic [C_BW-1:0] C_BLAST   = C_BW'(C_DW);
    localparam logic [C_BW-1:0] C_BPENULT = C_BW'(C_DW - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_SETUP    = 3'd1,
        S_SHIFT_HI = 3'd2,
        S_SHIFT_LO = 3'd3,
        S_GAP      = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [C_CW-1:0]   hcnt_q, hcnt_d;
    logic [C_BW-1:0]   bcnt_q, bcnt_d;
    logic [C_DW-1:0]   tx_q, tx_d;
    logic [C_DW-1:0]   rxsh_q, rxsh_d;
    logic [C_DW-1:0]   rx_q, rx_d;
    logic [1:0]        sel_q, sel_d;
    logic [2:0]        xss_q, xss_d;
    logic              sclk_q, sclk_d;
    logic              copi_q, copi_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [2:0]        sync1_q, sync2_q;
    logic              cipo_w;
    logic              tick_w;

    // Two-flop synchronizers on every CIPO line; selection happens after sync.
    always_ff @(posedge CK_i or posedge ARST_i) begin
        if (ARST_i) begin
            sync1_q <= 3'b000;
            sync2_q <= 3'b000;
        end else begin
            sync1_q <= {CIPO_2_i, CIPO_1_i, CIPO_0_i};
            sync2_q <= sync1_q;
        end
    end

    always_comb begin
        case (sel_q)
            2'd0:    cipo_w = sync2_q[0];
            2'd1:    cipo_w = sync2_q[1];
            default: cipo_w = sync2_q[2];
        endcase
    end

    assign tick_w = (hcnt_q == C_HLAST);

    always_ff @(posedge CK_i or posedge ARST_i) begin
        if (ARST_i) begin
            state_q <= S_IDLE;
            hcnt_q  <= '0;
            bcnt_q  <= '0;
            tx_q    <= '0;
            rxsh_q  <= '0;
            rx_q    <= '0;
            sel_q   <= 2'd0;
            xss_q   <= 3'b111;
            sclk_q  <= 1'b0;
            copi_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hcnt_q  <= hcnt_d;
            bcnt_q  <= bcnt_d;
            tx_q    <= tx_d;
            rxsh_q  <= rxsh_d;
            rx_q    <= rx_d;
            sel_q   <= sel_d;
            xss_q   <= xss_d;
            sclk_q  <= sclk_d;
            copi_q  <= copi_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        hcnt_d  = tick_w ? '0 : hcnt_q + 1'b1;
        bcnt_d  = bcnt_q;
        tx_d    = tx_q;
        rxsh_d  = rxsh_q;
        rx_d    = rx_q;
        sel_d   = sel_q;
        xss_d   = xss_q;
        sclk_d  = sclk_q;
        copi_d  = copi_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                hcnt_d = '0;
                if (REQ_i && (SEL_i != 2'd3)) begin
                    state_d = S_SETUP;
                    sel_d   = SEL_i;
                    tx_d    = TX_DAT_i;
                    copi_d  = TX_DAT_i[C_DW-1];
                    busy_d  = 1'b1;
                    sclk_d  = 1'b0;
                    bcnt_d  = '0;
                    xss_d   = ~(3'b001 << SEL_i);
                end
            end
            S_SETUP: begin
                if (tick_w) begin
                    state_d = S_SHIFT_HI;
                    sclk_d  = 1'b1;
                    rxsh_d  = {rxsh_q[C_DW-2:0], cipo_w};
                end
            end
            S_SHIFT_HI: begin
                if (tick_w) begin
                    state_d = S_SHIFT_LO;
                    sclk_d  = 1'b0;
                    bcnt_d  = bcnt_q + 1'b1;
                    // The final bit stays on COPI through the last low phase.
                    if (bcnt_q != C_BPENULT) begin
                        copi_d = tx_q[C_DW-2];
                        tx_d   = {tx_q[C_DW-2:0], 1'b0};
                    end
                end
            end
            S_SHIFT_LO: begin
                if (tick_w) begin
                    if (bcnt_q == C_BLAST) begin
                        state_d = S_GAP;
                        xss_d   = 3'b111;
                        copi_d  = 1'b0;
                        rx_d    = rxsh_q;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_SHIFT_HI;
                        sclk_d  = 1'b1;
                        rxsh_d  = {rxsh_q[C_DW-2:0], cipo_w};
                    end
                end
            end
            S_GAP: begin
                if (tick_w) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign BUSY_o   = busy_q;
    assign DONE_o   = done_q;
    assign RX_DAT_o = rx_q;
    assign SCLK_o   = sclk_q;
    assign COPI_o   = copi_q;
    assign XSS_0_o  = xss_q[0];
    assign XSS_1_o  = xss_q[1];
    assign XSS_2_o  = xss_q[2];

endmodule
`default_nettype wire

// File: tb/tb_spi3_master.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_spi3_master
// Purpose  : Scoreboard bench for spi3_master (H=2, 8-bit frames).
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi3_master;

    logic       CK_i = 1'b0;
    logic       ARST_i = 1'b1;
    logic       REQ_i = 1'b0;
    logic [1:0] SEL_i = 2'd0;
    logic [7:0] TX_DAT_i = 8'h00;
    logic       BUSY_o, DONE_o, SCLK_o, COPI_o;
    logic [7:0] RX_DAT_o;
    logic       XSS_0_o, XSS_1_o, XSS_2_o;
    logic       CIPO_0_i = 1'b0, CIPO_1_i = 1'b0, CIPO_2_i = 1'b0;

    always #5 CK_i = ~CK_i;

    spi3_master #(.C_F_CK(8), .C_F_SCLK(2), .C_DW(8)) dut (
        .CK_i(CK_i), .ARST_i(ARST_i), .REQ_i(REQ_i), .SEL_i(SEL_i),
        .TX_DAT_i(TX_DAT_i), .BUSY_o(BUSY_o), .DONE_o(DONE_o),
        .RX_DAT_o(RX_DAT_o), .SCLK_o(SCLK_o), .COPI_o(COPI_o),
        .XSS_0_o(XSS_0_o), .XSS_1_o(XSS_1_o), .XSS_2_o(XSS_2_o),
        .CIPO_0_i(CIPO_0_i), .CIPO_1_i(CIPO_1_i), .CIPO_2_i(CIPO_2_i)
    );

    int n_pass = 0;
    int n_checks = 0;

    task automatic check(input string nm, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    typedef struct {
        logic [1:0] sel;
        logic [7:0] tx;
        logic [7:0] rx;
    } exp_t;
    exp_t sb[$];

    // Slave model: holds each bit for a full SCLK period, advancing after a rise.
    logic [7:0] resp [3];
    int         sidx = 7;
    logic       s_psclk = 1'b0;
    always @(negedge CK_i) begin
        if ({XSS_2_o, XSS_1_o, XSS_0_o} == 3'b111) sidx = 7;
        else if (SCLK_o && !s_psclk && sidx > 0) sidx--;
        s_psclk  = SCLK_o;
        CIPO_0_i = resp[0][sidx];
        CIPO_1_i = resp[1][sidx];
        CIPO_2_i = resp[2][sidx];
    end

    // Monitor: per-frame pin statistics, checked against the scoreboard on DONE.
    int         busy_len = 0, xss_len = 0, rises = 0, done_len = 0, gap_len = 100;
    logic [7:0] copi_acc = 8'h00;
    logic [2:0] low_mask = 3'b000;
    logic       m_pb = 1'b0, m_ps = 1'b0, m_pd = 1'b0;
    always @(negedge CK_i) begin
        logic [2:0] xss;
        exp_t       e;
        xss = {XSS_2_o, XSS_1_o, XSS_0_o};
        if (ARST_i) begin
            busy_len = 0; xss_len = 0; rises = 0; done_len = 0; gap_len = 100;
            copi_acc = 8'h00; low_mask = 3'b000;
            m_pb = 1'b0; m_ps = 1'b0; m_pd = 1'b0;
        end else begin
            if (xss != 3'b111) begin
                if (xss_len == 0) check("xss_gap_ge3", int'(gap_len >= 3), 1);
                xss_len++;
                low_mask = low_mask | ~xss;
                gap_len = 0;
            end else begin
                gap_len++;
            end
            if (SCLK_o && !m_ps) begin
                rises++;
                copi_acc = {copi_acc[6:0], COPI_o};
            end
            if (BUSY_o) busy_len++;
            else if (m_pb) begin
                check("busy_len", busy_len, 36);
                busy_len = 0;
            end
            if (DONE_o) begin
                done_len++;
                if (!m_pd) begin
                    if (sb.size() == 0) begin
                        check("unexpected_done", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        check("rx_data", int'(RX_DAT_o), int'(e.rx));
                        check("copi_word", int'(copi_acc), int'(e.tx));
                        check("sclk_rises", rises, 8);
                        check("xss_low_len", xss_len, 34);
                        check("xss_mask", int'(low_mask), int'(3'b001 << e.sel));
                    end
                    xss_len = 0; rises = 0; low_mask = 3'b000; copi_acc = 8'h00;
                end
            end else if (m_pd) begin
                check("done_width", done_len, 1);
                done_len = 0;
            end
            m_pb = BUSY_o; m_ps = SCLK_o; m_pd = DONE_o;
        end
    end

    task automatic wait_busy(input logic lvl, input string nm);
        int cyc = 0;
        while (BUSY_o !== lvl && cyc < 200) begin
            @(negedge CK_i);
            cyc++;
        end
        if (BUSY_o !== lvl) check(nm, int'(BUSY_o), int'(lvl));
    endtask

    task automatic wait_falls(input int n);
        int   falls = 0;
        int   cyc = 0;
        logic p;
        p = BUSY_o;
        while (falls < n && cyc < 200 * n) begin
            @(negedge CK_i);
            if (p && !BUSY_o) falls++;
            p = BUSY_o;
            cyc++;
        end
        check("frames_completed", falls, n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        int nr;
        logic ps;
        resp[0] = 8'h00; resp[1] = 8'h00; resp[2] = 8'h00;

        repeat (3) @(negedge CK_i);
        #1 ARST_i = 1'b0;
        repeat (4) @(negedge CK_i);
        check("rst_busy", int'(BUSY_o), 0);
        check("rst_done", int'(DONE_o), 0);
        check("rst_sclk", int'(SCLK_o), 0);
        check("rst_copi", int'(COPI_o), 0);
        check("rst_xss", int'({XSS_2_o, XSS_1_o, XSS_0_o}), 3'b111);
        check("rst_rx", int'(RX_DAT_o), 0);

        // Single frame on slave 1.
        resp[1] = 8'h3C;
        @(negedge CK_i);
        REQ_i = 1'b1; SEL_i = 2'd1; TX_DAT_i = 8'hA5;
        sb.push_back('{sel: 2'd1, tx: 8'hA5, rx: 8'h3C});
        @(negedge CK_i);
        REQ_i = 1'b0;
        wait_falls(1);
        repeat (4) @(negedge CK_i);

        // Back-to-back frames on slave 0 with REQ held high.
        resp[0] = 8'h69;
        @(negedge CK_i);
        REQ_i = 1'b1; SEL_i = 2'd0; TX_DAT_i = 8'hFF;
        sb.push_back('{sel: 2'd0, tx: 8'hFF, rx: 8'h69});
        sb.push_back('{sel: 2'd0, tx: 8'h00, rx: 8'h69});
        wait_busy(1'b1, "b2b_start1");
        TX_DAT_i = 8'h00;
        wait_busy(1'b0, "b2b_end1");
        wait_busy(1'b1, "b2b_start2");
        REQ_i = 1'b0;
        wait_falls(1);
        repeat (4) @(negedge CK_i);

        // Invalid select is dropped.
        REQ_i = 1'b1; SEL_i = 2'd3; TX_DAT_i = 8'hF0;
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge CK_i);
            if (BUSY_o || DONE_o || SCLK_o || ({XSS_2_o, XSS_1_o, XSS_0_o} != 3'b111)) bad++;
        end
        REQ_i = 1'b0;
        check("sel3_idle_violations", bad, 0);

        // REQ/TX/SEL activity during a frame must be ignored.
        resp[2] = 8'h96;
        @(negedge CK_i);
        REQ_i = 1'b1; SEL_i = 2'd2; TX_DAT_i = 8'h5A;
        sb.push_back('{sel: 2'd2, tx: 8'h5A, rx: 8'h96});
        wait_busy(1'b1, "toggle_start");
        for (int i = 0; i < 30; i++) begin
            @(negedge CK_i);
            REQ_i = ~REQ_i;
            TX_DAT_i = TX_DAT_i + 8'h13;
            SEL_i = (SEL_i == 2'd0) ? 2'd1 : 2'd0;
        end
        REQ_i = 1'b0;
        wait_falls(1);
        repeat (4) @(negedge CK_i);

        // Async reset at the 4th SCLK rise aborts the frame without DONE.
        resp[2] = 8'hC3;
        @(negedge CK_i);
        REQ_i = 1'b1; SEL_i = 2'd2; TX_DAT_i = 8'h81;
        wait_busy(1'b1, "abort_start");
        REQ_i = 1'b0;
        nr = 0; ps = SCLK_o;
        for (int i = 0; i < 100 && nr < 4; i++) begin
            @(negedge CK_i);
            if (SCLK_o && !ps) nr++;
            ps = SCLK_o;
        end
        check("abort_rise_reached", nr, 4);
        #1 ARST_i = 1'b1;
        #1;
        check("abort_sclk", int'(SCLK_o), 0);
        check("abort_xss", int'({XSS_2_o, XSS_1_o, XSS_0_o}), 3'b111);
        check("abort_busy", int'(BUSY_o), 0);
        check("abort_done", int'(DONE_o), 0);
        @(negedge CK_i);
        #1 ARST_i = 1'b0;
        repeat (3) @(negedge CK_i);
        check("abort_rx_cleared", int'(RX_DAT_o), 0);

        REQ_i = 1'b1; SEL_i = 2'd2; TX_DAT_i = 8'h81;
        sb.push_back('{sel: 2'd2, tx: 8'h81, rx: 8'hC3});
        @(negedge CK_i);
        REQ_i = 1'b0;
        wait_falls(1);
        repeat (6) @(negedge CK_i);

        check("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
